// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes funct/ALUOp, runs single-cycle ADD/SUB/AND/OR and an
// iterative shift-add MUL, and returns a registered result over valid/ready.
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0]       funct_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [2:0]       op_o,
    output logic             busy_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid_o/result_o/op_o stay stable until ready_i is seen high.

    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [2:0] OP_ADDI = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2:0]       op_dec;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] partial;
    logic             accept;
    logic             unused_funct;

    assign unused_funct = funct_i[2];
    assign accept       = valid_i && ready_o;

    always_comb begin
        op_dec = OP_ADD;
        if (ALUOp_i != 2'b10)  op_dec = OP_ADDI;
        else if (funct_i[4])   op_dec = OP_SUB;
        else if (funct_i[3])   op_dec = OP_MUL;
        else if (funct_i[0])   op_dec = OP_AND;
        else if (funct_i[1])   op_dec = OP_OR;
    end

    always_comb begin
        case (op_dec)
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            default: alu_res = src1_i + src2_i;
        endcase
    end

    // One radix-2^MUL_BITS digit of the multiplier times the shifted multiplicand.
    always_comb begin
        digit                 = '0;
        digit[MUL_BITS-1:0]   = mplier_q[MUL_BITS-1:0];
        partial               = mcand_q * digit;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (op_dec == OP_MUL) ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (accept)       state_d = (op_dec == OP_MUL) ? S_MUL : S_DONE;
                else if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State outputs
    always_comb begin
        ready_o = rst_i && ((state_q == S_IDLE) || ((state_q == S_DONE) && ready_i));
        valid_o = (state_q == S_DONE);
        busy_o  = (state_q == S_MUL);
    end

    always_comb begin
        result_d = result_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept) begin
            op_d = op_dec;
            if (op_dec == OP_MUL) begin
                acc_d    = '0;
                mcand_d  = src1_i;
                mplier_d = src2_i;
                cnt_d    = CW'(STEPS);
            end else begin
                result_d = alu_res;
            end
        end else if (state_q == S_MUL) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) result_d = acc_q + partial;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            result_q <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            result_q <= result_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = (result_q == '0);
    assign op_o     = op_q;

endmodule
